// File: rtl/result_bcd_converter.sv
// Captures the accumulator result on a finish rise and converts it to packed BCD with
// sequential double dabble, one bit per cycle. Define LEADING_BLANK_EN to add the blank output.
module result_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  finish,
  input  logic [WIDTH-1:0]      result,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  overrun
`ifdef LEADING_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

  state_t          state_reg;
  logic            finish_d;
  logic [SW-1:0]   sr_reg;
  logic [CW-1:0]   cnt_reg;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   step;
  logic [BW-1:0]   conv_bcd;
  logic            rise;

  assign rise = finish & ~finish_d;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[WIDTH+4*gi +: 4] = (sr_reg[WIDTH+4*gi +: 4] >= 4'd5) ?
                                    sr_reg[WIDTH+4*gi +: 4] + 4'd3 :
                                    sr_reg[WIDTH+4*gi +: 4];
    end
  endgenerate
  assign adj[WIDTH-1:0] = sr_reg[WIDTH-1:0];
  assign step           = {adj[SW-2:0], 1'b0};
  assign conv_bcd       = step[SW-1:WIDTH];

`ifdef LEADING_BLANK_EN
  logic [DIGITS-1:0] zero_dig;
  logic [DIGITS-1:0] blank_next;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_blank
      assign zero_dig[gi] = (conv_bcd[4*gi +: 4] == 4'd0);
      // Digit 0 is never blanked so a zero value still shows one "0".
      if (gi == 0) begin : g_lsd
        assign blank_next[gi] = 1'b0;
      end else begin : g_upper
        assign blank_next[gi] = &zero_dig[DIGITS-1:gi];
      end
    end
  endgenerate
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      finish_d  <= 1'b0;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      bcd       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
`ifdef LEADING_BLANK_EN
      blank     <= '0;
`endif
    end else begin
      finish_d <= finish;
      // A rise outside IDLE is dropped; only the sticky flag records it.
      if (rise && state_reg != IDLE) overrun <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (rise) begin
            sr_reg    <= {{BW{1'b0}}, result};
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= CONVERT;
          end
        end
        CONVERT: begin
          sr_reg  <= step;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            bcd       <= conv_bcd;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state_reg <= HOLD;
`ifdef LEADING_BLANK_EN
            blank     <= blank_next;
`endif
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
